pixel_frame_tx: RTL and testbench
=================================

# pixel_frame_tx

Transmit side of the byte-pixel link into the Gaussian/Sobel frame filter. The block buffers an upstream pixel stream and emits whole N×M frames as one unbroken run of `data_valid` bytes, which is what the filter's storage counter needs. It holds off each new frame until the filter's `fill_now` status has gone quiet. If a mid-frame underrun occurs, it aborts the frame cleanly so filter and transmitter both realign at the next frame boundary.

## Interface
Parameters:
- `N`, 450, image rows
- `M`, 600, image columns
- `FIFO_DEPTH`, 16, input FIFO entries (power of two)
- `PREFILL`, 8, FIFO occupancy required before a frame starts (≤ FIFO_DEPTH)
- `GAP_CYCLES`, 4, idle cycles forced after every frame
- `BUSY_QUIET`, 4, consecutive cycles `busy_in` must be low before a frame starts

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `s_data`  in  8  upstream pixel byte
- `s_valid`  in  1  upstream byte valid
- `s_ready`  out  1  FIFO can accept; transfer when `s_valid & s_ready`
- `busy_in`  in  1  filter `fill_now`; high means the filter is still processing
- `Dout`  out  8  pixel byte to filter `Din`
- `data_valid`  out  1  to filter `data_valid`; high for exactly N*M contiguous cycles per good frame
- `frame_done`  out  1  one-cycle pulse after the last byte of a good frame
- `err_underrun`  out  1  sticky; set on mid-frame FIFO empty; cleared only by `rst`
- `frame_cnt`  out  16  good frames sent, wraps 0xFFFF→0

## Operation
- FSM states are IDLE, SEND, FLUSH and GAP. Reset enters IDLE.
- IDLE:
  - `quiet_cnt` counts consecutive low `busy_in` cycles, saturating at BUSY_QUIET.
  - Any high `busy_in` cycle clears `quiet_cnt`.
  - IDLE→SEND when `quiet_cnt==BUSY_QUIET` and FIFO occupancy ≥ PREFILL.
- SEND:
  - Each cycle pops one FIFO byte into the `Dout` register with `data_valid=1`, and increments `pix_cnt` (width clog2(N*M)).
  - When `pix_cnt==N*M-1` is popped: go to GAP, pulse `frame_done` on the cycle after the last `data_valid`, increment `frame_cnt`, clear `pix_cnt`.
  - `busy_in` is ignored in SEND.
- Underrun: FIFO empty in SEND → `data_valid=0` that cycle, set `err_underrun`, go to FLUSH. `pix_cnt` is kept.
- FLUSH:
  - Pops and discards bytes (`data_valid` stays 0), incrementing `pix_cnt` per discarded byte until it reaches N*M-1.
  - Then goes to GAP with no `frame_done` and no `frame_cnt` increment.
- GAP: counts GAP_CYCLES with `data_valid=0`, then returns to IDLE. Entering GAP clears `quiet_cnt`, because the filter drops its storage index on any `data_valid` low.
- FIFO:
  - `s_ready = !full` whenever out of reset. Push and pop in the same cycle is allowed and leaves occupancy unchanged.
  - On a full FIFO, `s_ready=0`; no data is ever dropped at the input.

## Timing
- All outputs are registered.
- Reset values: `Dout=0`, `data_valid=0`, `frame_done=0`, `err_underrun=0`, `frame_cnt=0`, `s_ready=0` during the reset cycle, FIFO empty.
- Latency:
  - Cycle of the IDLE→SEND decision = T. First `data_valid` at T+1.
  - Last byte at T+N*M. `frame_done` at T+N*M+1.
  - Earliest next frame start ≥ GAP_CYCLES + BUSY_QUIET cycles later.
- Upstream byte to `Dout`: minimum 1 cycle after the FIFO write, subject to PREFILL.
- `rst` mid-frame drops `data_valid` on the next edge and empties the FIFO. The partial frame is lost and the filter resynchronises on the low `data_valid`.

## Configuration
- `PIXEL_TX_CHECKSUM_EN` defined:
  - Adds output `frame_sum[15:0]`, the mod-2^16 sum of all bytes sent in the frame.
  - It is updated in the same cycle as `frame_done` and holds until the next `frame_done`. Reset value is 0.
  - Aborted frames do not update it.
- Not defined: no port and no adder logic.

## Structure
- Package `pixel_stream_pkg` holds:
  - the state enum `tx_state_t` (IDLE, SEND, FLUSH, GAP);
  - default `N`/`M`;
  - localparam `FRAME_PIX = N*M`;
  - the pixel byte typedef.
- Sub-module `pixel_sync_fifo` is a single-clock FIFO with `rst`, push/pop, full/empty and occupancy count. The top level contains the FSM and counters.

## Test plan
Bench parameters are N=4, M=5 (20 pixels), FIFO_DEPTH=8, PREFILL=4, GAP_CYCLES=3, BUSY_QUIET=2.
- Continuous upstream bytes 0..19, `busy_in=0` → `data_valid` high 20 contiguous cycles, `Dout` 0..19 in order, `frame_done` one cycle after byte 19, `frame_cnt=1`.
- `busy_in` toggling 1/0 every cycle, then held low → SEND not entered until 2 consecutive low cycles. First `data_valid` on the cycle after the second low cycle.
- Upstream stalls after 10 bytes → `data_valid` drops after byte 9 and `err_underrun=1`. The next 10 bytes are discarded with `data_valid=0`, `frame_done` never pulses, `frame_cnt` unchanged, and the following frame sends normally.
- Upstream holds `s_valid` with the FIFO full during `busy_in=1` → `s_ready=0`, no byte lost; occupancy stays 8 until SEND.
- `rst` asserted on byte 7 of a frame → next cycle `data_valid=0`, `s_ready=0`, all outputs at reset values. A new frame starts from byte 0 after reset.
- `PIXEL_TX_CHECKSUM_EN` with bytes 0..19 → `frame_sum=190` with `frame_done`. With 20 bytes of 0xFF → `frame_sum=0x13EC`.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared types and defaults for the byte-pixel transmit path into the frame filter.
package pixel_stream_pkg;

  localparam int DEF_N     = 450;
  localparam int DEF_M     = 600;
  localparam int FRAME_PIX = DEF_N * DEF_M;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FLUSH,
    GAP
  } tx_state_t;

endpackage

// File: rtl/pixel_frame_tx_if.sv
// Upstream valid/ready byte stream feeding pixel_frame_tx.
interface pixel_frame_tx_if;
  import pixel_stream_pkg::*;

  pixel_t s_data;
  logic   s_valid;
  logic   s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/pixel_sync_fifo.sv
// Single-clock pixel FIFO with occupancy count; ready is registered and low in reset.
module pixel_sync_fifo
  import pixel_stream_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pixel_t        din,
  output logic          ready,
  input  logic          pop,
  output pixel_t        dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_nx;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    case ({do_push, do_pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      ready <= (count_nx != CW'(DEPTH));
    end
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_frame_tx.sv
// Frame transmitter: buffers upstream bytes and sends whole N*M frames as one data_valid run.
// Optional PIXEL_TX_CHECKSUM_EN adds a per-frame mod-2^16 byte sum output (frame_sum).
module pixel_frame_tx
  import pixel_stream_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int M          = DEF_M,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8,
  parameter int GAP_CYCLES = 4,
  parameter int BUSY_QUIET = 4
) (
  input  logic            clk,
  input  logic            rst,
  pixel_frame_tx_if.slave s,
  input  logic            busy_in,
  output pixel_t          Dout,
  output logic            data_valid,
  output logic            frame_done,
  output logic            err_underrun,
  output logic [15:0]     frame_cnt
`ifdef PIXEL_TX_CHECKSUM_EN
  ,
  output logic [15:0]     frame_sum
`endif
);

  localparam int FRAME_N = N * M;
  localparam int PIX_W   = $clog2(FRAME_N);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int QW      = $clog2(BUSY_QUIET + 1);
  localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  function automatic logic [QW-1:0] quiet_sat_inc(input logic [QW-1:0] q);
    return (q == QW'(BUSY_QUIET)) ? q : q + QW'(1);
  endfunction

`ifdef PIXEL_TX_CHECKSUM_EN
  function automatic logic [15:0] sum_wrap_add(input logic [15:0] acc, input pixel_t b);
    return acc + 16'(b);
  endfunction

  logic [15:0] run_sum;
`endif

  tx_state_t        state;
  logic [QW-1:0]    quiet_cnt;
  logic [QW-1:0]    quiet_nx;
  logic [PIX_W-1:0] pix_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             done_p1;
  logic             go;
  logic             last;
  logic             pop;
  logic             fifo_ready;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  pixel_t           fifo_dout;

  assign s.s_ready = fifo_ready;

  pixel_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s.s_valid),
    .din   (s.s_data),
    .ready (fifo_ready),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The start decision includes this cycle's busy_in so the first byte follows the last quiet cycle directly.
  always_comb begin
    quiet_nx = busy_in ? '0 : quiet_sat_inc(quiet_cnt);
    go       = (quiet_nx == QW'(BUSY_QUIET)) && (fifo_count >= CNT_W'(PREFILL));
    last     = (pix_cnt == PIX_W'(FRAME_N - 1));
    pop      = 1'b0;
    case (state)
      IDLE:        pop = go;
      SEND, FLUSH: pop = !fifo_empty;
      default:     pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      quiet_cnt    <= '0;
      pix_cnt      <= '0;
      gap_cnt      <= '0;
      Dout         <= '0;
      data_valid   <= 1'b0;
      done_p1      <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      frame_cnt    <= '0;
`ifdef PIXEL_TX_CHECKSUM_EN
      run_sum      <= '0;
      frame_sum    <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      done_p1    <= 1'b0;
      frame_done <= done_p1;
      if (done_p1) begin
        frame_cnt <= frame_cnt + 16'd1;
`ifdef PIXEL_TX_CHECKSUM_EN
        frame_sum <= run_sum;
`endif
      end
      case (state)
        IDLE: begin
          quiet_cnt <= quiet_nx;
          if (go) begin
            state      <= SEND;
            Dout       <= fifo_dout;
            data_valid <= 1'b1;
            pix_cnt    <= PIX_W'(1);
`ifdef PIXEL_TX_CHECKSUM_EN
            run_sum    <= 16'(fifo_dout);
`endif
          end
        end
        SEND: begin
          if (fifo_empty) begin
            err_underrun <= 1'b1;
            state        <= FLUSH;
          end else begin
            Dout       <= fifo_dout;
            data_valid <= 1'b1;
`ifdef PIXEL_TX_CHECKSUM_EN
            run_sum    <= sum_wrap_add(run_sum, fifo_dout);
`endif
            if (last) begin
              state     <= GAP;
              pix_cnt   <= '0;
              gap_cnt   <= '0;
              quiet_cnt <= '0;
              done_p1   <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        FLUSH: begin
          // Drain the rest of the aborted frame so the next frame starts on a boundary.
          if (!fifo_empty) begin
            if (last) begin
              state     <= GAP;
              pix_cnt   <= '0;
              gap_cnt   <= '0;
              quiet_cnt <= '0;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
          else                                gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Scoreboard bench for pixel_frame_tx with a 4x5 frame and small FIFO/gap settings.
module tb_pixel_frame_tx;
  import pixel_stream_pkg::*;

  localparam int N     = 4;
  localparam int M     = 5;
  localparam int FD    = 8;
  localparam int PRE   = 4;
  localparam int GAPC  = 3;
  localparam int QUIET = 2;
  localparam int FRAME = N * M;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy_in = 1'b0;
  pixel_t      Dout;
  logic        data_valid;
  logic        frame_done;
  logic        err_underrun;
  logic [15:0] frame_cnt;
`ifdef PIXEL_TX_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif

  int     vectors = 0;
  int     miscompares = 0;
  logic [8:0] src_q [$];
  pixel_t exp_q [$];
  pixel_t mon_exp;

  pixel_frame_tx_if s_if ();

  pixel_frame_tx #(
    .N(N), .M(M), .FIFO_DEPTH(FD), .PREFILL(PRE), .GAP_CYCLES(GAPC), .BUSY_QUIET(QUIET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (s_if),
    .busy_in      (busy_in),
    .Dout         (Dout),
    .data_valid   (data_valid),
    .frame_done   (frame_done),
    .err_underrun (err_underrun),
    .frame_cnt    (frame_cnt)
`ifdef PIXEL_TX_CHECKSUM_EN
    ,
    .frame_sum    (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  // Upstream driver: s_ready is stable between edges, so the transfer at the next edge is known here.
  always @(negedge clk) begin
    #1;
    if (src_q.size() > 0) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = src_q[0][7:0];
      if (s_if.s_ready) begin
        if (src_q[0][8]) exp_q.push_back(src_q[0][7:0]);
        void'(src_q.pop_front());
      end
    end else begin
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
    end
  end

  // Output monitor against the scoreboard.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dout_unexpected: got %0d, required no data_valid", Dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (Dout !== mon_exp) begin
          miscompares++;
          $display("FAIL dout_order: got %0d, required %0d", Dout, mon_exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic enqueue(input int first, input int cnt, input bit keep, input bit all_ff);
    pixel_t b;
    for (int i = 0; i < cnt; i++) begin
      b = all_ff ? 8'hFF : 8'(first + i);
      src_q.push_back({keep, b});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    busy_in = 1'b0;
    src_q.delete();
    exp_q.delete();
    tick();
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dv: got %0d, required 0", data_valid); end
    vectors++; if (Dout !== 8'd0) begin miscompares++; $display("FAIL reset_dout: got %0d, required 0", Dout); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0d, required 0", frame_done); end
    vectors++; if (err_underrun !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0d, required 0", err_underrun); end
    vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d, required 0", frame_cnt); end
    vectors++; if (s_if.s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0d, required 0", s_if.s_ready); end
`ifdef PIXEL_TX_CHECKSUM_EN
    vectors++; if (frame_sum !== 16'd0) begin miscompares++; $display("FAIL reset_sum: got %0d, required 0", frame_sum); end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_frame(input bit all_ff);
    int dv_n = 0, first = -1, last = -1, gaps = 0, fd_n = 0, fd_at = -1;
    logic [15:0] exp_sum = '0;
    do_reset();
    busy_in = 1'b0;
    for (int i = 0; i < FRAME; i++) exp_sum = exp_sum + (all_ff ? 16'hFF : 16'(i));
    enqueue(0, FRAME, 1'b1, all_ff);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (data_valid) begin
        if (first < 0) first = c;
        else if (c != last + 1) gaps++;
        last = c;
        dv_n++;
      end
      if (frame_done) begin
        fd_n++;
        fd_at = c;
`ifdef PIXEL_TX_CHECKSUM_EN
        vectors++; if (frame_sum !== exp_sum) begin miscompares++; $display("FAIL frame_sum: got %0d, required %0d", frame_sum, exp_sum); end
`endif
      end
    end
    vectors++; if (dv_n != FRAME) begin miscompares++; $display("FAIL frame_dv_count: got %0d, required %0d", dv_n, FRAME); end
    vectors++; if (gaps != 0) begin miscompares++; $display("FAIL frame_contiguous: got %0d breaks, required 0", gaps); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL frame_done_pulses: got %0d, required 1", fd_n); end
    vectors++; if (fd_at != last + 1) begin miscompares++; $display("FAIL frame_done_timing: got cycle %0d, required %0d", fd_at, last + 1); end
    vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL frame_cnt: got %0d, required 1", frame_cnt); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL frame_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_busy_quiet();
    int early = 0, dv_n = 0, fd_n = 0;
    do_reset();
    busy_in = 1'b1;
    enqueue(0, FRAME, 1'b1, 1'b0);
    repeat (14) begin
      tick();
      if (data_valid) early++;
    end
    vectors++; if (s_if.s_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0d, required 0", s_if.s_ready); end
    vectors++; if (src_q.size() != FRAME - FD) begin miscompares++; $display("FAIL full_accepted: got %0d left, required %0d", src_q.size(), FRAME - FD); end
    for (int i = 0; i < 6; i++) begin
      busy_in = (i % 2 == 1);
      tick();
      if (data_valid) early++;
    end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL busy_early: got %0d dv cycles, required 0", early); end
    vectors++; if (s_if.s_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: got %0d, required 0", s_if.s_ready); end
    busy_in = 1'b0;
    tick();
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL quiet_one_low: got %0d, required 0", data_valid); end
    tick();
    vectors++; if (data_valid !== 1'b1) begin miscompares++; $display("FAIL quiet_two_low: got %0d, required 1", data_valid); end
    if (data_valid) dv_n = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (data_valid) dv_n++;
      if (frame_done) fd_n++;
    end
    vectors++; if (dv_n != FRAME) begin miscompares++; $display("FAIL busy_dv_count: got %0d, required %0d", dv_n, FRAME); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL busy_done: got %0d, required 1", fd_n); end
    vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL busy_cnt: got %0d, required 1", frame_cnt); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL busy_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_underrun();
    int dv1 = 0, dv2 = 0, fd1 = 0, fd2 = 0;
    bit seen = 1'b0;
    do_reset();
    busy_in = 1'b0;
    enqueue(0, 10, 1'b1, 1'b0);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (data_valid) dv1++;
      if (frame_done) fd1++;
      if (err_underrun) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++; if (seen != 1'b1) begin miscompares++; $display("FAIL underrun_flag: got %0d, required 1", err_underrun); end
    vectors++; if (dv1 != 10) begin miscompares++; $display("FAIL underrun_sent: got %0d, required 10", dv1); end
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL underrun_dv: got %0d, required 0", data_valid); end
    vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL underrun_cnt: got %0d, required 0", frame_cnt); end
    enqueue(50, 10, 1'b0, 1'b0);
    enqueue(100, FRAME, 1'b1, 1'b0);
    for (int c = 0; c < 80; c++) begin
      tick();
      if (data_valid) dv2++;
      if (frame_done) fd2++;
    end
    vectors++; if (fd1 + fd2 != 1) begin miscompares++; $display("FAIL underrun_done: got %0d, required 1", fd1 + fd2); end
    vectors++; if (dv2 != FRAME) begin miscompares++; $display("FAIL underrun_next: got %0d, required %0d", dv2, FRAME); end
    vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL underrun_cnt2: got %0d, required 1", frame_cnt); end
    vectors++; if (err_underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky: got %0d, required 1", err_underrun); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL underrun_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_midframe_reset();
    int dv_n = 0, fd_n = 0;
    bit hit = 1'b0;
    do_reset();
    busy_in = 1'b0;
    enqueue(0, FRAME, 1'b1, 1'b0);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (data_valid && Dout == 8'd7) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++; if (hit != 1'b1) begin miscompares++; $display("FAIL rst_byte7_reached: got %0d, required 1", hit); end
    rst = 1'b1;
    src_q.delete();
    exp_q.delete();
    tick();
    vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_dv: got %0d, required 0", data_valid); end
    vectors++; if (s_if.s_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: got %0d, required 0", s_if.s_ready); end
    vectors++; if (Dout !== 8'd0) begin miscompares++; $display("FAIL rstmid_dout: got %0d, required 0", Dout); end
    vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL rstmid_cnt: got %0d, required 0", frame_cnt); end
    tick();
    rst = 1'b0;
    enqueue(200, FRAME, 1'b1, 1'b0);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (data_valid) dv_n++;
      if (frame_done) fd_n++;
    end
    vectors++; if (dv_n != FRAME) begin miscompares++; $display("FAIL rstmid_next: got %0d, required %0d", dv_n, FRAME); end
    vectors++; if (fd_n != 1) begin miscompares++; $display("FAIL rstmid_done: got %0d, required 1", fd_n); end
    vectors++; if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL rstmid_cnt2: got %0d, required 1", frame_cnt); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rstmid_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int runs = 0, dv_n = 0, fd_n = 0, c_last = -1, gap = -1;
    bit prev_dv = 1'b0;
    do_reset();
    busy_in = 1'b0;
    enqueue(0, 2 * FRAME, 1'b1, 1'b0);
    for (int c = 0; c < 100; c++) begin
      tick();
      if (data_valid) begin
        if (!prev_dv) begin
          runs++;
          if (runs == 2) gap = c - c_last;
        end
        c_last = c;
        dv_n++;
      end
      prev_dv = data_valid;
      if (frame_done) fd_n++;
    end
    vectors++; if (runs != 2) begin miscompares++; $display("FAIL b2b_runs: got %0d, required 2", runs); end
    vectors++; if (dv_n != 2 * FRAME) begin miscompares++; $display("FAIL b2b_dv: got %0d, required %0d", dv_n, 2 * FRAME); end
    vectors++; if (gap < GAPC + QUIET) begin miscompares++; $display("FAIL b2b_gap: got %0d, required at least %0d", gap, GAPC + QUIET); end
    vectors++; if (fd_n != 2) begin miscompares++; $display("FAIL b2b_done: got %0d, required 2", fd_n); end
    vectors++; if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL b2b_cnt: got %0d, required 2", frame_cnt); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_left: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_busy_quiet();
    test_underrun();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
